fifo_modport: RTL and testbench

- Synchronous single-clock FIFO; decouples a producer and a consumer within one clock domain.
- Sits behind the team's FIFO interface bundle, which carries `w_en`, `r_en`, `data_in`, `data_out`, `full` and `empty` between the bench or upstream logic and the storage.
- Provides registered `full`/`empty` status and a registered read-data output.
- Overflow and underflow attempts are dropped with no state change.

---
 rtl/fifo_modport_if.sv | 21 ++
 rtl/fifo_modport.sv | 86 ++++++++
 tb/tb_fifo_modport.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fifo_modport_if.sv
// FIFO handshake bundle: master drives requests/write data, slave returns read data and status.
interface fifo_modport_if #(
  parameter int WIDTH = 8
) ();
  logic             w_en;
  logic             r_en;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;

  modport master (
    output w_en, r_en, data_in,
    input  data_out, full, empty
  );

  modport slave (
    input  w_en, r_en, data_in,
    output data_out, full, empty
  );
endinterface

// File: rtl/fifo_modport.sv
// Synchronous single-clock FIFO with registered flags and read data.
// Define FIFO_ASSERT_EN to compile the built-in protocol assertions.
module fifo_modport #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  fifo_modport_if.slave bus
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             wr_ok;
  logic             rd_ok;

  // Acceptance uses the registered flags, so a full FIFO with a concurrent
  // read still refuses the write and the written slot never aliases the read.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    wr_ok     = bus.w_en && !bus.full;
    rd_ok     = bus.r_en && !bus.empty;
    count_nxt = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      bus.full     <= 1'b0;
      bus.empty    <= 1'b1;
      bus.data_out <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr       <= rd_ptr + 1'b1;
        bus.data_out <= mem[rd_ptr];
      end
      count     <= count_nxt;
      bus.full  <= (count_nxt == FULL_CNT);
      bus.empty <= (count_nxt == '0);
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem[wr_ptr] <= bus.data_in;
  end

`ifdef FIFO_ASSERT_EN
  a_fill_sets_full: assert property (@(posedge clk) disable iff (rst)
    (bus.empty && bus.w_en && !bus.r_en) ##1
    (bus.w_en && !bus.r_en && !bus.full) [*(DEPTH - 1)] |=> bus.full)
    else $error("fifo_modport: full not set after DEPTH writes from empty");

  a_drain_sets_empty: assert property (@(posedge clk) disable iff (rst)
    (bus.r_en && !bus.w_en) [*DEPTH] |=> bus.empty)
    else $error("fifo_modport: empty not set within DEPTH reads");

  a_flags_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(bus.full && bus.empty))
    else $error("fifo_modport: full and empty both high");

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(bus.w_en && bus.full))
    else $error("fifo_modport: write while full");

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(bus.r_en && bus.empty))
    else $error("fifo_modport: read while empty");
`endif

endmodule

// File: tb/tb_fifo_modport.sv
// Directed plus random test of fifo_modport against a queue-based reference model.
module tb_fifo_modport;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] model_dout;

  fifo_modport_if #(.WIDTH(WIDTH)) bus ();

  fifo_modport #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] observed,
                       input logic [WIDTH-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the FIFO rules, then compare.
  task automatic step(input string tag, input logic r, input logic w_v,
                      input logic r_v, input logic [WIDTH-1:0] d);
    bit wr_ok;
    bit rd_ok;
    rst         = r;
    bus.w_en    = w_v;
    bus.r_en    = r_v;
    bus.data_in = d;
    @(posedge clk);
    if (r) begin
      model_q.delete();
      model_dout = '0;
    end else begin
      wr_ok = w_v && (model_q.size() < DEPTH);
      rd_ok = r_v && (model_q.size() > 0);
      if (rd_ok) model_dout = model_q.pop_front();
      if (wr_ok) model_q.push_back(d);
    end
    #1;
    check({tag, ".empty"},    WIDTH'(bus.empty), WIDTH'(model_q.size() == 0));
    check({tag, ".full"},     WIDTH'(bus.full),  WIDTH'(model_q.size() == DEPTH));
    check({tag, ".data_out"}, bus.data_out,      model_dout);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    model_dout  = '0;
    rst         = 1'b1;
    bus.w_en    = 1'b0;
    bus.r_en    = 1'b0;
    bus.data_in = '0;

    // Reset overrides concurrent requests.
    for (int i = 0; i < 2; i++) step("reset", 1'b1, 1'b1, 1'b1, 8'hEE);
    check("reset.dout_zero", bus.data_out, 8'h00);

    // Fill, then an overflow attempt.
    for (int i = 1; i <= DEPTH; i++) step("fill", 1'b0, 1'b1, 1'b0, WIDTH'(i));
    check("fill.full_set", WIDTH'(bus.full), 8'h01);
    step("overflow", 1'b0, 1'b1, 1'b0, 8'hFF);

    // Drain in order, then an underflow attempt.
    for (int i = 1; i <= DEPTH; i++) begin
      step("drain", 1'b0, 1'b0, 1'b1, 8'h00);
      check("drain.order", bus.data_out, WIDTH'(i));
    end
    step("underflow", 1'b0, 1'b0, 1'b1, 8'h00);
    check("underflow.hold", bus.data_out, 8'h08);

    // Wrap-around.
    for (int i = 0; i < 5; i++) step("wrap.w5", 1'b0, 1'b1, 1'b0, WIDTH'(8'h30 + i));
    for (int i = 0; i < 5; i++) step("wrap.r5", 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < DEPTH; i++) step("wrap.fill", 1'b0, 1'b1, 1'b0, WIDTH'(8'hA0 + i));
    check("wrap.full_set", WIDTH'(bus.full), 8'h01);
    for (int i = 0; i < DEPTH; i++) begin
      step("wrap.drain", 1'b0, 1'b0, 1'b1, 8'h00);
      check("wrap.order", bus.data_out, WIDTH'(8'hA0 + i));
    end

    // Simultaneous read/write at occupancy 3.
    for (int i = 0; i < 3; i++) step("sim.pre", 1'b0, 1'b1, 1'b0, WIDTH'(8'h10 + i));
    for (int i = 0; i < 10; i++) step("sim.rw", 1'b0, 1'b1, 1'b1, WIDTH'(8'h20 + i));
    check("sim.occupancy", WIDTH'(model_q.size()), 8'h03);

    // Simultaneous read/write while full: write dropped.
    for (int i = 0; i < 5; i++) step("simfull.pre", 1'b0, 1'b1, 1'b0, WIDTH'(8'h40 + i));
    step("simfull.rw", 1'b0, 1'b1, 1'b1, 8'hCC);
    check("simfull.full_clr", WIDTH'(bus.full), 8'h00);
    for (int i = 0; i < DEPTH; i++) step("simfull.drain", 1'b0, 1'b0, 1'b1, 8'h00);

    // Reset mid-stream.
    for (int i = 0; i < 4; i++) step("mid.pre", 1'b0, 1'b1, 1'b0, WIDTH'(8'h60 + i));
    step("mid.rst", 1'b1, 1'b0, 1'b0, 8'h00);
    step("mid.w", 1'b0, 1'b1, 1'b0, 8'h5A);
    step("mid.r", 1'b0, 1'b0, 1'b1, 8'h00);
    check("mid.data", bus.data_out, 8'h5A);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 59) == 0), ($urandom_range(0, 99) < 55),
           ($urandom_range(0, 99) < 50), WIDTH'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
